ps2_scancode_rx: RTL and testbench

- Parametrised PS/2 device-to-host receiver. Successor to the PS/2 keyboard test path: replaces the vendor PS/2 core plus raw-pin hex display.
- Deframes 11-bit PS/2 frames and checks start, odd parity and stop bits.
- Buffers good bytes in a FIFO with a valid/ready consumer interface.
- Keeps a shift-register history of the last HIST_BYTES bytes for direct display on the board hex digits.

---
 rtl/ps2_scancode_rx.sv | 236 +++++++++++++++++++++++
 tb/tb_ps2_scancode_rx.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx : PS/2 device-to-host receiver.
//   Conditions the asynchronous PS/2 lines, deframes 11-bit frames
//   (start, 8 data LSB-first, odd parity, stop) and buffers good bytes in a
//   first-word-fall-through FIFO. A shift-register history of the most recent
//   good bytes drives the board hex display directly.
//
// Ports
//   CLOCK_50    system clock
//   reset       synchronous active-high reset
//   PS2_CLK     PS/2 clock line (async, idle high)
//   PS2_DATA    PS/2 data line (async, idle high)
//   rx_data     FIFO head byte, valid while rx_valid=1
//   rx_valid    FIFO not empty
//   rx_ready    consumer takes the head byte this cycle
//   fifo_count  occupied FIFO entries
//   history     last HIST_BYTES good bytes, newest in [7:0]
//   frame_err   one-cycle pulse on framing / parity / timeout error
//   overflow    sticky: a good byte was dropped on a full FIFO
//
// state  | meaning
// IDLE   | waiting for a start bit
// DATA   | shifting in the 8 data bits, LSB first
// PARITY | waiting for the parity bit
// STOP   | waiting for the stop bit, then judge the frame
module ps2_scancode_rx #(
   parameter int unsigned CLK_HZ     = 50_000_000,
   parameter int unsigned TIMEOUT_US = 100,
   parameter int unsigned FIFO_DEPTH = 8,
   parameter int unsigned HIST_BYTES = 2,
   parameter int unsigned FILTER_LEN = 4
) (
   input  logic                              CLOCK_50,
   input  logic                              reset,
   input  logic                              PS2_CLK,
   input  logic                              PS2_DATA,
   output logic [7:0]                        rx_data,
   output logic                              rx_valid,
   input  logic                              rx_ready,
   output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count,
   output logic [8*HIST_BYTES-1:0]           history,
   output logic                              frame_err,
   output logic                              overflow
);

   localparam int unsigned TIMEOUT_CYCLES = CLK_HZ / 1000000 * TIMEOUT_US;
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned FW = $clog2(FILTER_LEN + 1);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned HW = 8 * HIST_BYTES;

   typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

   // input conditioning
   logic          clk_meta_q, clk_sync_q, dat_meta_q, dat_sync_q;
   logic          filt_q, filt_d;
   logic [FW-1:0] flt_cnt_q, flt_cnt_d;
   logic          fall;

   // deframer
   state_t        state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          tmo_hit;
   logic          frame_ok;
   logic          err_q, err_d;
   logic          push_q, push_d;
   logic [7:0]    push_byte_q, push_byte_d;

   // fifo and history
   logic [7:0]    mem_q [FIFO_DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          ovf_q, ovf_d;
   logic [HW-1:0] hist_q, hist_d;
   logic          pop, push_ok;

   // Filter: the level flips only once FILTER_LEN consecutive samples disagree.
   always_comb begin
      filt_d    = filt_q;
      flt_cnt_d = '0;
      fall      = 1'b0;
      if (clk_sync_q != filt_q) begin
         if (flt_cnt_q == FW'(FILTER_LEN - 1)) begin
            filt_d = ~filt_q;
            fall   = filt_q;
         end else begin
            flt_cnt_d = flt_cnt_q + 1'b1;
         end
      end
   end

   // A fall in the same cycle as the terminal count wins: the edge arrived in time.
   assign tmo_hit = (state_q != IDLE) && !fall && (tmo_q == TW'(TIMEOUT_CYCLES - 1));

   // state register
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         state_q   <= IDLE;
         bit_cnt_q <= '0;
         shift_q   <= '0;
         par_q     <= 1'b0;
         tmo_q     <= '0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         par_q     <= par_d;
         tmo_q     <= tmo_d;
      end
   end

   // next-state logic
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      par_d     = par_q;
      tmo_d     = '0;
      if (state_q != IDLE && !fall && !tmo_hit)
         tmo_d = tmo_q + 1'b1;
      case (state_q)
         IDLE: begin
            if (fall && !dat_sync_q) begin
               state_d   = DATA;
               bit_cnt_d = '0;
               shift_d   = '0;
            end
         end
         DATA: begin
            if (fall) begin
               shift_d   = {dat_sync_q, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 1'b1;
               if (bit_cnt_q == 3'd7)
                  state_d = PARITY;
            end
         end
         PARITY: begin
            if (fall) begin
               par_d   = dat_sync_q;
               state_d = STOP;
            end
         end
         STOP: begin
            if (fall)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (tmo_hit)
         state_d = IDLE;
   end

   // output logic: frame judgement, registered into push / frame_err
   always_comb begin
      frame_ok    = dat_sync_q & (^shift_q ^ par_q);
      push_byte_d = shift_q;
      push_d      = fall && (state_q == STOP) && frame_ok;
      err_d       = tmo_hit ||
                    (fall && (state_q == IDLE) && dat_sync_q) ||
                    (fall && (state_q == STOP) && !frame_ok);
   end

   // FIFO and history
   always_comb begin
      pop     = (cnt_q != '0) && rx_ready;
      push_ok = push_q && ((cnt_q != CW'(FIFO_DEPTH)) || pop);
      wr_d    = wr_q;
      rd_d    = rd_q;
      cnt_d   = cnt_q;
      if (push_ok)
         wr_d = wr_q + 1'b1;
      if (pop)
         rd_d = rd_q + 1'b1;
      if (push_ok && !pop)
         cnt_d = cnt_q + 1'b1;
      else if (!push_ok && pop)
         cnt_d = cnt_q - 1'b1;
      ovf_d  = ovf_q | (push_q & ~push_ok);
      hist_d = hist_q;
      if (push_q) begin
         hist_d      = hist_q << 8;
         hist_d[7:0] = push_byte_q;
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         clk_meta_q  <= 1'b1;
         clk_sync_q  <= 1'b1;
         dat_meta_q  <= 1'b1;
         dat_sync_q  <= 1'b1;
         filt_q      <= 1'b1;
         flt_cnt_q   <= '0;
         err_q       <= 1'b0;
         push_q      <= 1'b0;
         push_byte_q <= '0;
         wr_q        <= '0;
         rd_q        <= '0;
         cnt_q       <= '0;
         ovf_q       <= 1'b0;
         hist_q      <= '0;
      end else begin
         clk_meta_q  <= PS2_CLK;
         clk_sync_q  <= clk_meta_q;
         dat_meta_q  <= PS2_DATA;
         dat_sync_q  <= dat_meta_q;
         filt_q      <= filt_d;
         flt_cnt_q   <= flt_cnt_d;
         err_q       <= err_d;
         push_q      <= push_d;
         push_byte_q <= push_byte_d;
         wr_q        <= wr_d;
         rd_q        <= rd_d;
         cnt_q       <= cnt_d;
         ovf_q       <= ovf_d;
         hist_q      <= hist_d;
      end
   end

   // Storage needs no reset; the occupancy count alone defines validity.
   always_ff @(posedge CLOCK_50) begin
      if (push_ok)
         mem_q[wr_q] <= push_byte_q;
   end

   assign rx_data    = mem_q[rd_q];
   assign rx_valid   = (cnt_q != '0);
   assign fifo_count = cnt_q;
   assign history    = hist_q;
   assign frame_err  = err_q;
   assign overflow   = ovf_q;

endmodule

// File: tb/tb_ps2_scancode_rx.sv
// Directed bench for ps2_scancode_rx at a reduced clock rate: 2 MHz gives a
// 40-cycle PS/2 bit period (20 us) and a 200-cycle frame timeout.
module tb_ps2_scancode_rx;

   localparam int unsigned CLK_HZ     = 2_000_000;
   localparam int unsigned TIMEOUT_US = 100;
   localparam int unsigned FIFO_DEPTH = 8;
   localparam int unsigned HIST_BYTES = 2;
   localparam int unsigned FILTER_LEN = 4;
   localparam int unsigned TMO_CYC    = CLK_HZ / 1000000 * TIMEOUT_US;
   localparam int          HALF_BIT   = 20;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ps2_clk = 1'b1;
   logic        ps2_data = 1'b1;
   logic        rx_ready = 1'b0;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic [3:0]  fifo_count;
   logic [15:0] history;
   logic        frame_err;
   logic        overflow;

   ps2_scancode_rx #(
      .CLK_HZ(CLK_HZ), .TIMEOUT_US(TIMEOUT_US), .FIFO_DEPTH(FIFO_DEPTH),
      .HIST_BYTES(HIST_BYTES), .FILTER_LEN(FILTER_LEN)
   ) dut (
      .CLOCK_50(clk), .reset(reset), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .fifo_count(fifo_count), .history(history), .frame_err(frame_err),
      .overflow(overflow)
   );

   always #5 clk = ~clk;

   int         n_chk = 0;
   int         n_fail = 0;
   int         cyc = 0;
   int         err_cnt = 0;
   int         last_err_cyc = 0;
   logic [7:0] pop_q[$];
   int         pop_rd = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Observe away from the active edge.
   always @(negedge clk) begin
      if (frame_err) begin
         err_cnt++;
         last_err_cyc = cyc;
      end
      if (rx_valid && rx_ready)
         pop_q.push_back(rx_data);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_chk++;
      if (obs !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
      end
   endtask

   // Inputs change 1 time unit after a rising edge.
   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      ps2_data = b;
      wait_cyc(HALF_BIT);
      ps2_clk = 1'b0;
      wait_cyc(HALF_BIT);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic flip_par);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit((~^b) ^ flip_par);
      send_bit(1'b1);
      wait_cyc(30);
   endtask

   task automatic expect_pop(input string tag, input logic [7:0] expv);
      if (pop_rd < pop_q.size()) begin
         check(tag, {24'h0, pop_q[pop_rd]}, {24'h0, expv});
         pop_rd++;
      end else begin
         check(tag, 32'h100, {24'h0, expv});
      end
   endtask

   initial begin
      int e0;
      int c0;
      bit seen;

      // reset values
      wait_cyc(3);
      check("rst_valid", rx_valid, 0);
      check("rst_count", fifo_count, 0);
      check("rst_hist", history, 0);
      check("rst_err", frame_err, 0);
      check("rst_ovf", overflow, 0);
      reset = 1'b0;
      wait_cyc(5);

      // single good frame, consumer always ready
      rx_ready = 1'b1;
      send_frame(8'h1C, 1'b0);
      expect_pop("pop_1c", 8'h1C);
      check("hist_1c", history, 16'h001C);
      check("err_1c", err_cnt, 0);
      check("cnt_1c", fifo_count, 0);

      // two frames buffered, then drained in order
      rx_ready = 1'b0;
      send_frame(8'hF0, 1'b0);
      send_frame(8'h1C, 1'b0);
      check("hist_f01c", history, 16'hF01C);
      check("cnt_2", fifo_count, 2);
      check("head_f0", rx_data, 8'hF0);
      rx_ready = 1'b1;
      wait_cyc(5);
      expect_pop("pop_f0", 8'hF0);
      expect_pop("pop_1c_b", 8'h1C);
      check("cnt_drain", fifo_count, 0);

      // bad parity: one error, nothing stored
      e0 = err_cnt;
      send_frame(8'h1C, 1'b1);
      check("par_err", err_cnt - e0, 1);
      check("par_cnt", fifo_count, 0);
      check("par_hist", history, 16'hF01C);
      check("par_nopop", pop_q.size() - pop_rd, 0);
      send_frame(8'h5A, 1'b0);
      expect_pop("pop_5a", 8'h5A);
      check("hist_5a", history, 16'h1C5A);

      // clock glitch one sample shorter than the filter
      e0 = err_cnt;
      ps2_clk = 1'b0;
      wait_cyc(FILTER_LEN - 1);
      ps2_clk = 1'b1;
      wait_cyc(20);
      check("glitch_err", err_cnt - e0, 0);
      check("glitch_hist", history, 16'h1C5A);

      // timeout after start + 3 data bits
      e0 = err_cnt;
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      ps2_data = 1'b1;
      wait_cyc(HALF_BIT);
      ps2_clk = 1'b0;
      c0 = cyc;
      seen = 1'b0;
      for (int k = 1; k <= 1000 && !seen; k++) begin
         wait_cyc(1);
         if (k == HALF_BIT) ps2_clk = 1'b1;
         if (err_cnt != e0) seen = 1'b1;
      end
      ps2_clk = 1'b1;
      // 2 sync flops + FILTER_LEN filter samples, then the timeout itself
      check("tmo_delay", seen ? (last_err_cyc - c0) : 32'hFFFF_FFFF, FILTER_LEN + 2 + TMO_CYC);
      wait_cyc(20);
      check("tmo_once", err_cnt - e0, 1);
      send_frame(8'h1C, 1'b0);
      expect_pop("pop_1c_tmo", 8'h1C);
      check("hist_tmo", history, 16'h5A1C);

      // overflow: nine frames into an eight-deep FIFO
      rx_ready = 1'b0;
      for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b0);
      check("ovf_cnt", fifo_count, 8);
      check("ovf_flag", overflow, 1);
      check("ovf_hist", history, 16'h0809);
      rx_ready = 1'b1;
      wait_cyc(20);
      for (int i = 1; i <= 8; i++) expect_pop($sformatf("drain_%0d", i), 8'(i));
      check("drain_cnt", fifo_count, 0);
      check("ovf_sticky", overflow, 1);

      // reset in the middle of a frame
      rx_ready = 1'b0;
      send_frame(8'h77, 1'b0);
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      e0 = err_cnt;
      reset = 1'b1;
      wait_cyc(1);
      check("mid_valid", rx_valid, 0);
      check("mid_cnt", fifo_count, 0);
      check("mid_hist", history, 0);
      check("mid_ovf", overflow, 0);
      check("mid_err", frame_err, 0);
      reset = 1'b0;
      wait_cyc(TMO_CYC + 100);
      check("mid_noerr", err_cnt - e0, 0);
      rx_ready = 1'b1;
      send_frame(8'h42, 1'b0);
      expect_pop("pop_42", 8'h42);
      check("hist_42", history, 16'h0042);
      check("no_extra_pops", pop_q.size() - pop_rd, 0);

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
